// File: rtl/ip_lpm_pipe_pkg.sv
// Shared route-entry widths, pipeline latency and helpers for ip_lpm_pipe.
package ip_lpm_pipe_pkg;
  localparam int unsigned IP_W             = 32;
  localparam int unsigned MASK_W           = 32;
  localparam int unsigned NH_W             = 32;
  localparam int unsigned HALF_W           = 16;
  localparam int unsigned LPM_PIPE_LATENCY = 4;

  typedef enum logic {WR_IDLE, WR_PEND} lpm_wr_state_t;

  function automatic int unsigned lpm_log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((32'd1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/ip_lpm_pipe_prio_enc.sv
// Lowest-index priority encoder over the route match vector, with any-hit flag.
module lpm_prio_enc
  import ip_lpm_pipe_pkg::*;
#(
  parameter int unsigned LUT_DEPTH      = 32,
  parameter int unsigned LUT_DEPTH_BITS = lpm_log2(LUT_DEPTH)
) (
  input  logic [LUT_DEPTH-1:0]      match,
  output logic [LUT_DEPTH_BITS-1:0] idx,
  output logic                      hit
);
  always_comb begin
    idx = '0;
    for (int unsigned i = LUT_DEPTH; i > 0; i--)
      if (match[i-1]) idx = LUT_DEPTH_BITS'(i - 1);
  end

  assign hit = |match;
endmodule

// File: rtl/ip_lpm_pipe.sv
// Four-stage longest-prefix-match lookup over a register route table.
// Optional hit/miss statistics counters: define LPM_STATS_EN.
module ip_lpm_pipe
  import ip_lpm_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned NUM_QUEUES     = 8,
  parameter int unsigned LUT_DEPTH      = 32,
  parameter int unsigned LUT_DEPTH_BITS = lpm_log2(LUT_DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      word_IP_SRC_DST,
  input  logic                      word_IP_DST_LO,
  output logic [IP_W-1:0]           next_hop_ip,
  output logic [NUM_QUEUES-1:0]     lpm_output_port,
  output logic                      lpm_vld,
  output logic                      lpm_hit,
  input  logic [LUT_DEPTH_BITS-1:0] lpm_rd_addr,
  input  logic                      lpm_rd_req,
  output logic [IP_W-1:0]           lpm_rd_ip,
  output logic [MASK_W-1:0]         lpm_rd_mask,
  output logic [NH_W-1:0]           lpm_rd_next_hop_ip,
  output logic [NUM_QUEUES-1:0]     lpm_rd_oq,
  output logic                      lpm_rd_valid,
  output logic                      lpm_rd_ack,
  input  logic [LUT_DEPTH_BITS-1:0] lpm_wr_addr,
  input  logic                      lpm_wr_req,
  input  logic [IP_W-1:0]           lpm_wr_ip,
  input  logic [MASK_W-1:0]         lpm_wr_mask,
  input  logic [NH_W-1:0]           lpm_wr_next_hop_ip,
  input  logic [NUM_QUEUES-1:0]     lpm_wr_oq,
  input  logic                      lpm_wr_valid,
  output logic                      lpm_wr_ack,
  output logic                      ready_out,
  output logic [31:0]               lpm_hit_cnt,
  output logic [31:0]               lpm_miss_cnt
);
  logic [LUT_DEPTH-1:0]  tbl_valid;
  logic [IP_W-1:0]       tbl_ip   [LUT_DEPTH];
  logic [MASK_W-1:0]     tbl_mask [LUT_DEPTH];
  logic [NH_W-1:0]       tbl_nh   [LUT_DEPTH];
  logic [NUM_QUEUES-1:0] tbl_oq   [LUT_DEPTH];

  // S0: assemble the destination address from the header words
  logic [HALF_W-1:0] dst_hi, hi_sel;
  logic              s1_vld;
  logic [IP_W-1:0]   s1_dst;
  logic              in_data_unused;

  assign hi_sel         = word_IP_SRC_DST ? in_data[HALF_W-1:0] : dst_hi;
  assign in_data_unused = ^in_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      dst_hi <= '0;
      s1_vld <= 1'b0;
      s1_dst <= '0;
    end else begin
      if (word_IP_SRC_DST) dst_hi <= in_data[HALF_W-1:0];
      s1_vld <= word_IP_DST_LO;
      if (word_IP_DST_LO) s1_dst <= {hi_sel, in_data[DATA_WIDTH-1 -: HALF_W]};
    end
  end

  // S1: parallel masked compare
  logic [LUT_DEPTH-1:0] match, s2_match;
  logic                 s2_vld;
  logic [IP_W-1:0]      s2_dst;

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < LUT_DEPTH; i++)
      match[i] = tbl_valid[i] && (((s1_dst ^ tbl_ip[i]) & tbl_mask[i]) == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_vld   <= 1'b0;
      s2_match <= '0;
      s2_dst   <= '0;
    end else begin
      s2_vld   <= s1_vld;
      s2_match <= match;
      s2_dst   <= s1_dst;
    end
  end

  // S2: priority encode
  logic [LUT_DEPTH_BITS-1:0] enc_idx, s3_idx;
  logic                      enc_hit, s3_hit, s3_vld;
  logic [IP_W-1:0]           s3_dst;

  lpm_prio_enc #(
    .LUT_DEPTH      (LUT_DEPTH),
    .LUT_DEPTH_BITS (LUT_DEPTH_BITS)
  ) u_prio_enc (
    .match (s2_match),
    .idx   (enc_idx),
    .hit   (enc_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s3_vld <= 1'b0;
      s3_idx <= '0;
      s3_hit <= 1'b0;
      s3_dst <= '0;
    end else begin
      s3_vld <= s2_vld;
      s3_idx <= enc_idx;
      s3_hit <= enc_hit;
      s3_dst <= s2_dst;
    end
  end

  // S3: entry read and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      lpm_vld         <= 1'b0;
      lpm_hit         <= 1'b0;
      lpm_output_port <= '0;
      next_hop_ip     <= '0;
    end else begin
      lpm_vld <= s3_vld;
      if (s3_vld) begin
        lpm_hit         <= s3_hit;
        lpm_output_port <= s3_hit ? tbl_oq[s3_idx] : '0;
        next_hop_ip     <= (s3_hit && tbl_nh[s3_idx] != '0) ? tbl_nh[s3_idx] : s3_dst;
      end
    end
  end

  // Writes wait while a lookup sits between compare and priority encode, so
  // the entry read at S3 is the one that produced the match.
  lpm_wr_state_t             wr_state, wr_state_nxt;
  logic                      wr_go, wr_hold;
  logic [LUT_DEPTH_BITS-1:0] wq_addr, we_addr;
  logic [IP_W-1:0]           wq_ip, we_ip;
  logic [MASK_W-1:0]         wq_mask, we_mask;
  logic [NH_W-1:0]           wq_nh, we_nh;
  logic [NUM_QUEUES-1:0]     wq_oq, we_oq;
  logic                      wq_valid, we_valid;

  assign wr_hold   = s1_vld | s2_vld;
  assign ready_out = (wr_state == WR_IDLE);
  assign we_addr   = (wr_state == WR_PEND) ? wq_addr  : lpm_wr_addr;
  assign we_ip     = (wr_state == WR_PEND) ? wq_ip    : lpm_wr_ip;
  assign we_mask   = (wr_state == WR_PEND) ? wq_mask  : lpm_wr_mask;
  assign we_nh     = (wr_state == WR_PEND) ? wq_nh    : lpm_wr_next_hop_ip;
  assign we_oq     = (wr_state == WR_PEND) ? wq_oq    : lpm_wr_oq;
  assign we_valid  = (wr_state == WR_PEND) ? wq_valid : lpm_wr_valid;

  always_comb begin
    wr_state_nxt = wr_state;
    wr_go        = 1'b0;
    case (wr_state)
      WR_IDLE: if (lpm_wr_req) begin
        if (!wr_hold) wr_go = 1'b1;
        else          wr_state_nxt = WR_PEND;
      end
      WR_PEND: if (!wr_hold) begin
        wr_go        = 1'b1;
        wr_state_nxt = WR_IDLE;
      end
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state   <= WR_IDLE;
      lpm_wr_ack <= 1'b0;
      wq_addr    <= '0;
      wq_ip      <= '0;
      wq_mask    <= '0;
      wq_nh      <= '0;
      wq_oq      <= '0;
      wq_valid   <= 1'b0;
    end else begin
      wr_state   <= wr_state_nxt;
      lpm_wr_ack <= wr_go;
      if (wr_state == WR_IDLE && lpm_wr_req) begin
        wq_addr  <= lpm_wr_addr;
        wq_ip    <= lpm_wr_ip;
        wq_mask  <= lpm_wr_mask;
        wq_nh    <= lpm_wr_next_hop_ip;
        wq_oq    <= lpm_wr_oq;
        wq_valid <= lpm_wr_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tbl_valid <= '0;
      for (int unsigned i = 0; i < LUT_DEPTH; i++) begin
        tbl_ip[i]   <= '0;
        tbl_mask[i] <= '0;
        tbl_nh[i]   <= '0;
        tbl_oq[i]   <= '0;
      end
    end else if (wr_go) begin
      tbl_valid[we_addr] <= we_valid;
      tbl_ip[we_addr]    <= we_ip;
      tbl_mask[we_addr]  <= we_mask;
      tbl_nh[we_addr]    <= we_nh;
      tbl_oq[we_addr]    <= we_oq;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lpm_rd_ack         <= 1'b0;
      lpm_rd_valid       <= 1'b0;
      lpm_rd_ip          <= '0;
      lpm_rd_mask        <= '0;
      lpm_rd_next_hop_ip <= '0;
      lpm_rd_oq          <= '0;
    end else begin
      lpm_rd_ack <= lpm_rd_req;
      if (lpm_rd_req) begin
        lpm_rd_valid       <= tbl_valid[lpm_rd_addr];
        lpm_rd_ip          <= tbl_ip[lpm_rd_addr];
        lpm_rd_mask        <= tbl_mask[lpm_rd_addr];
        lpm_rd_next_hop_ip <= tbl_nh[lpm_rd_addr];
        lpm_rd_oq          <= tbl_oq[lpm_rd_addr];
      end
    end
  end

`ifdef LPM_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      lpm_hit_cnt  <= '0;
      lpm_miss_cnt <= '0;
    end else if (lpm_vld) begin
      if (lpm_hit && lpm_hit_cnt != '1)        lpm_hit_cnt  <= lpm_hit_cnt + 32'd1;
      else if (!lpm_hit && lpm_miss_cnt != '1) lpm_miss_cnt <= lpm_miss_cnt + 32'd1;
    end
  end
`else
  assign lpm_hit_cnt  = '0;
  assign lpm_miss_cnt = '0;
`endif
endmodule

// File: tb/tb_ip_lpm_pipe.sv
// Randomized self-checking bench for ip_lpm_pipe against a route-table reference model.
module tb_ip_lpm_pipe;
  import ip_lpm_pipe_pkg::*;

  localparam int DW = 64, NQ = 8, DEPTH = 32, AB = 5, NC = 4096;
`ifdef LPM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          word_IP_SRC_DST = 1'b0, word_IP_DST_LO = 1'b0;
  logic [31:0]   next_hop_ip;
  logic [NQ-1:0] lpm_output_port;
  logic          lpm_vld, lpm_hit;
  logic [AB-1:0] lpm_rd_addr = '0;
  logic          lpm_rd_req = 1'b0;
  logic [31:0]   lpm_rd_ip, lpm_rd_mask, lpm_rd_next_hop_ip;
  logic [NQ-1:0] lpm_rd_oq;
  logic          lpm_rd_valid, lpm_rd_ack;
  logic [AB-1:0] lpm_wr_addr = '0;
  logic          lpm_wr_req = 1'b0;
  logic [31:0]   lpm_wr_ip = '0, lpm_wr_mask = '0, lpm_wr_next_hop_ip = '0;
  logic [NQ-1:0] lpm_wr_oq = '0;
  logic          lpm_wr_valid = 1'b0;
  logic          lpm_wr_ack, ready_out;
  logic [31:0]   lpm_hit_cnt, lpm_miss_cnt;

  ip_lpm_pipe #(
    .DATA_WIDTH (DW),
    .NUM_QUEUES (NQ),
    .LUT_DEPTH  (DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data),
    .word_IP_SRC_DST(word_IP_SRC_DST), .word_IP_DST_LO(word_IP_DST_LO),
    .next_hop_ip(next_hop_ip), .lpm_output_port(lpm_output_port),
    .lpm_vld(lpm_vld), .lpm_hit(lpm_hit),
    .lpm_rd_addr(lpm_rd_addr), .lpm_rd_req(lpm_rd_req),
    .lpm_rd_ip(lpm_rd_ip), .lpm_rd_mask(lpm_rd_mask),
    .lpm_rd_next_hop_ip(lpm_rd_next_hop_ip), .lpm_rd_oq(lpm_rd_oq),
    .lpm_rd_valid(lpm_rd_valid), .lpm_rd_ack(lpm_rd_ack),
    .lpm_wr_addr(lpm_wr_addr), .lpm_wr_req(lpm_wr_req),
    .lpm_wr_ip(lpm_wr_ip), .lpm_wr_mask(lpm_wr_mask),
    .lpm_wr_next_hop_ip(lpm_wr_next_hop_ip), .lpm_wr_oq(lpm_wr_oq),
    .lpm_wr_valid(lpm_wr_valid), .lpm_wr_ack(lpm_wr_ack),
    .ready_out(ready_out), .lpm_hit_cnt(lpm_hit_cnt), .lpm_miss_cnt(lpm_miss_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, cyc = 4;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // reference route table and pending write
  bit          m_valid [DEPTH];
  logic [31:0] m_ip [DEPTH], m_mask [DEPTH], m_nh [DEPTH];
  logic [NQ-1:0] m_oq [DEPTH];
  bit          m_pend;
  logic [AB-1:0] p_addr;
  logic [31:0] p_ip, p_mask, p_nh;
  logic [NQ-1:0] p_oq;
  bit          p_valid;
  logic [15:0] m_hi;
  int unsigned m_hits, m_miss;

  // expectations indexed by cycle
  bit          launch [NC];
  bit          e_vld [NC], e_hit [NC], e_rack [NC], e_rvalid [NC], e_wack [NC];
  logic [NQ-1:0] e_port [NC], e_roq [NC];
  logic [31:0] e_nh [NC], e_rip [NC], e_rmask [NC], e_rnh [NC];

  // stimulus for the next cycle
  bit          st_reset, st_src, st_lo, st_rd, st_wr, st_wr_valid;
  logic [DW-1:0] st_data;
  logic [AB-1:0] st_rd_addr, st_wr_addr;
  logic [31:0] st_wr_ip, st_wr_mask, st_wr_nh;
  logic [NQ-1:0] st_wr_oq;

  logic        last_hit, last_rd_valid;
  logic [NQ-1:0] last_port, last_rd_oq;
  logic [31:0] last_nh, last_rd_nh;

  logic [31:0] pool [8] = '{32'h0A010203, 32'h0A010299, 32'h0A01FF00, 32'h0A7F0001,
                            32'hC0A80101, 32'hC0A80202, 32'h08080808, 32'h0A010200};

  function automatic logic [31:0] len2mask(input int len);
    logic [63:0] t;
    t = 64'hFFFF_FFFF << (32 - len);
    return t[31:0];
  endfunction

  // lowest index whose masked prefix equals the destination wins
  task automatic ref_lookup(input logic [31:0] d, output bit hit,
                            output logic [NQ-1:0] port, output logic [31:0] nh);
    hit = 1'b0; port = '0; nh = d;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i] && ((d & m_mask[i]) == (m_ip[i] & m_mask[i]))) begin
        hit = 1'b1;
        port = m_oq[i];
        nh = (m_nh[i] == 0) ? d : m_nh[i];
        break;
      end
    end
  endtask

  task automatic clear_stim();
    st_reset = 0; st_src = 0; st_lo = 0; st_rd = 0; st_wr = 0; st_wr_valid = 0;
    st_data = '0; st_rd_addr = '0; st_wr_addr = '0;
    st_wr_ip = '0; st_wr_mask = '0; st_wr_nh = '0; st_wr_oq = '0;
  endtask

  task automatic step();
    int c;
    bit h;
    logic [NQ-1:0] pt;
    logic [31:0] nh, d;
    c = cyc;
    chk("lpm_vld", lpm_vld, e_vld[c]);
    if (e_vld[c]) begin
      chk("lpm_hit", lpm_hit, e_hit[c]);
      chk("lpm_output_port", lpm_output_port, e_port[c]);
      chk("next_hop_ip", next_hop_ip, e_nh[c]);
    end
    if (lpm_vld) begin last_hit = lpm_hit; last_port = lpm_output_port; last_nh = next_hop_ip; end
    chk("lpm_hit_cnt", lpm_hit_cnt, STATS ? m_hits : 0);
    chk("lpm_miss_cnt", lpm_miss_cnt, STATS ? m_miss : 0);
    if (e_vld[c]) begin if (e_hit[c]) m_hits++; else m_miss++; end
    chk("lpm_rd_ack", lpm_rd_ack, e_rack[c]);
    if (e_rack[c]) begin
      chk("lpm_rd_valid", lpm_rd_valid, e_rvalid[c]);
      chk("lpm_rd_ip", lpm_rd_ip, e_rip[c]);
      chk("lpm_rd_mask", lpm_rd_mask, e_rmask[c]);
      chk("lpm_rd_next_hop_ip", lpm_rd_next_hop_ip, e_rnh[c]);
      chk("lpm_rd_oq", lpm_rd_oq, e_roq[c]);
    end
    if (lpm_rd_ack) begin last_rd_valid = lpm_rd_valid; last_rd_nh = lpm_rd_next_hop_ip; last_rd_oq = lpm_rd_oq; end
    chk("lpm_wr_ack", lpm_wr_ack, e_wack[c]);
    chk("ready_out", ready_out, !m_pend);

    if (st_reset) begin
      for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 0; m_ip[i] = 0; m_mask[i] = 0; m_nh[i] = 0; m_oq[i] = 0; end
      m_pend = 0; m_hi = '0; m_hits = 0; m_miss = 0;
      launch[c] = 0; launch[c-1] = 0;
      for (int j = 1; j <= LPM_PIPE_LATENCY; j++) e_vld[c+j] = 0;
      e_rack[c+1] = 0; e_wack[c+1] = 0;
    end else begin
      if (st_rd) begin
        e_rack[c+1] = 1; e_rvalid[c+1] = m_valid[st_rd_addr]; e_rip[c+1] = m_ip[st_rd_addr];
        e_rmask[c+1] = m_mask[st_rd_addr]; e_rnh[c+1] = m_nh[st_rd_addr]; e_roq[c+1] = m_oq[st_rd_addr];
      end
      if (st_wr && !m_pend) begin
        m_pend = 1; p_addr = st_wr_addr; p_ip = st_wr_ip; p_mask = st_wr_mask;
        p_nh = st_wr_nh; p_oq = st_wr_oq; p_valid = st_wr_valid;
      end
      // a write may not land while a lookup launched one or two cycles ago is between compare and encode
      if (m_pend && !launch[c-1] && !launch[c-2]) begin
        m_valid[p_addr] = p_valid; m_ip[p_addr] = p_ip; m_mask[p_addr] = p_mask;
        m_nh[p_addr] = p_nh; m_oq[p_addr] = p_oq;
        m_pend = 0; e_wack[c+1] = 1;
      end
      if (st_src) m_hi = st_data[15:0];
      launch[c] = st_lo;
      if (st_lo) begin
        d = {m_hi, st_data[DW-1 -: 16]};
        ref_lookup(d, h, pt, nh);
        e_vld[c+LPM_PIPE_LATENCY] = 1; e_hit[c+LPM_PIPE_LATENCY] = h;
        e_port[c+LPM_PIPE_LATENCY] = pt; e_nh[c+LPM_PIPE_LATENCY] = nh;
      end
    end

    reset = st_reset; in_data = st_data;
    word_IP_SRC_DST = st_src; word_IP_DST_LO = st_lo;
    lpm_rd_req = st_rd; lpm_rd_addr = st_rd_addr;
    lpm_wr_req = st_wr; lpm_wr_addr = st_wr_addr; lpm_wr_ip = st_wr_ip; lpm_wr_mask = st_wr_mask;
    lpm_wr_next_hop_ip = st_wr_nh; lpm_wr_oq = st_wr_oq; lpm_wr_valid = st_wr_valid;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    clear_stim();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic set_lookup(input logic [31:0] d);
    st_src = 1; st_lo = 1; st_data = {d[15:0], 32'h0, d[31:16]};
  endtask

  task automatic set_wr(input int a, input logic [31:0] ip, input logic [31:0] mask,
                        input logic [NQ-1:0] oq, input logic [31:0] nh, input bit v);
    st_wr = 1; st_wr_addr = AB'(a); st_wr_ip = ip; st_wr_mask = mask;
    st_wr_oq = oq; st_wr_nh = nh; st_wr_valid = v;
  endtask

  task automatic clear_last();
    last_hit = 1'bx; last_port = 'x; last_nh = 'x;
    last_rd_valid = 1'bx; last_rd_nh = 'x; last_rd_oq = 'x;
  endtask

  task automatic rand_stim();
    logic [31:0] d;
    int len;
    st_data = {$urandom, $urandom};
    d = ($urandom_range(0, 3) != 0) ? pool[$urandom_range(0, 7)] : $urandom;
    st_src = ($urandom_range(0, 9) < 4);
    st_lo  = ($urandom_range(0, 9) < 5);
    if (st_src) st_data[15:0] = d[31:16];
    if (st_lo)  st_data[DW-1 -: 16] = d[15:0];
    if ($urandom_range(0, 9) < 2) begin st_rd = 1; st_rd_addr = AB'($urandom_range(0, DEPTH - 1)); end
    if ($urandom_range(0, 9) < 2) begin
      len = int'($urandom_range(0, 32));
      set_wr(int'($urandom_range(0, 15)), pool[$urandom_range(0, 7)], len2mask(len),
             NQ'($urandom), ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
             $urandom_range(0, 7) != 0);
    end
    if ($urandom_range(0, 499) == 0) st_reset = 1;
  endtask

  initial begin
    clear_stim();
    clear_last();
    for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 0; m_ip[i] = 0; m_mask[i] = 0; m_nh[i] = 0; m_oq[i] = 0; end
    m_pend = 0; m_hi = '0; m_hits = 0; m_miss = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", lpm_vld, 0);
    chk("rst_port", lpm_output_port, 0);
    chk("rst_next_hop", next_hop_ip, 0);
    chk("rst_ready", ready_out, 1);
    chk("rst_wr_ack", lpm_wr_ack, 0);
    chk("rst_hit_cnt", lpm_hit_cnt, 0);

    // miss on empty table returns the destination itself
    set_lookup(32'h0A000001); step(); idle(4);
    chk("miss_hit", last_hit, 0);
    chk("miss_port", last_port, 0);
    chk("miss_hop", last_nh, 32'h0A000001);

    set_wr(0, 32'h0A010000, 32'hFFFF0000, 8'h04, 32'h0A090909, 1); step();
    set_wr(1, 32'h00000000, 32'h00000000, 8'h01, 32'h00000000, 1); step();
    clear_last(); set_lookup(32'h0A010203); step(); idle(4);
    chk("pfx16_hit", last_hit, 1);
    chk("pfx16_port", last_port, 8'h04);
    chk("pfx16_hop", last_nh, 32'h0A090909);
    clear_last(); set_lookup(32'h08080808); step(); idle(4);
    chk("dflt_hit", last_hit, 1);
    chk("dflt_port", last_port, 8'h01);
    chk("dflt_hop", last_nh, 32'h08080808);

    // back-to-back lookups
    set_lookup(32'h0A010000); step();
    set_lookup(32'hC0A80101); step();
    set_lookup(32'h0A01FFFF); step();
    set_lookup(32'h0A020304); step();
    idle(4);

    // write arriving while a lookup is in compare returns old-table data
    clear_last(); set_lookup(32'h0A010505); step();
    set_wr(0, 32'h0A010000, 32'hFFFF0000, 8'h20, 32'h0B0B0B0B, 1); step();
    idle(5);
    chk("hold_port", last_port, 8'h04);
    chk("hold_hop", last_nh, 32'h0A090909);

    // read and write same entry in the same cycle
    clear_last(); st_rd = 1; st_rd_addr = AB'(1);
    set_wr(1, 32'h00000000, 32'h00000000, 8'h80, 32'h01010101, 1); step(); idle(1);
    chk("rdw_old_oq", last_rd_oq, 8'h01);
    chk("rdw_old_hop", last_rd_nh, 32'h0);
    st_rd = 1; st_rd_addr = AB'(1); step(); idle(1);
    chk("rdw_new_oq", last_rd_oq, 8'h80);
    chk("rdw_new_hop", last_rd_nh, 32'h01010101);

    // reset with lookups in flight and a held write
    set_lookup(32'h0A010101); step();
    set_lookup(32'h0A010102); set_wr(2, 32'h0, 32'h0, 8'h02, 32'h0, 1); step();
    st_reset = 1; step(); idle(6);
    clear_last(); st_rd = 1; st_rd_addr = AB'(0); step(); idle(1);
    chk("rst_tbl_valid", last_rd_valid, 0);

    // statistics: 2 misses then 3 hits
    set_lookup(32'h01020304); step();
    set_lookup(32'h05060708); step();
    idle(4);
    set_wr(3, 32'h0, 32'h0, 8'h02, 32'h01020304, 1); step();
    set_lookup(32'h0A0B0C0D); step();
    set_lookup(32'h0A0B0C0E); step();
    set_lookup(32'h0A0B0C0F); step();
    idle(5);
    chk("stats_hits", lpm_hit_cnt, STATS ? 3 : 0);
    chk("stats_miss", lpm_miss_cnt, STATS ? 2 : 0);

    for (int n = 0; n < 1500; n++) begin
      rand_stim();
      step();
    end
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
